// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// phase-counter width calculation.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

  // Width of the shared HIGH/GAP down-counter; never narrower than one bit so
  // that WIDTH=GAP=1 still yields a legal vector.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the HIGH and GAP phases; done is high when
// the count has reached zero, and the count then holds at zero.
module pulse_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into WIDTH-cycle pulses separated by at least
// GAP low cycles. Define PULSE_STRETCHER_QUEUE_EN to queue triggers that arrive
// while busy; otherwise such triggers are dropped and flagged in overflow.
//
// Handshake: none. `in` is a plain level sampled every rising edge; each cycle
// it is high counts as one trigger, with no back-pressure toward the source.
module pulse_stretcher import pulse_pkg::*; #(
  parameter int WIDTH  = 4,
  parameter int GAP    = 1,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              clr_overflow,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output pulse_state_t      dbg_state
);

  localparam int CW = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);

  pulse_state_t  state_q;
  pulse_state_t  state_d;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          take_direct;
  logic          pend_nz;
  logic          extra;
  logic          drop;
  logic          out_q;
  logic          out_d;
  logic          ovf_q;
  logic          ovf_d;

  pulse_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A trigger in the last GAP cycle restarts HIGH directly and takes priority
  // over replaying a queued trigger, so the queue count is left untouched.
  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_val     = HIGH_LOAD;
    take_direct = 1'b0;
    case (state_q)
      IDLE: begin
        if (in) begin
          state_d     = HIGH;
          tmr_load    = 1'b1;
          take_direct = 1'b1;
        end
      end
      HIGH: begin
        if (tmr_done) begin
          state_d  = pulse_pkg::GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      pulse_pkg::GAP: begin
        if (tmr_done) begin
          if (in) begin
            state_d     = HIGH;
            tmr_load    = 1'b1;
            take_direct = 1'b1;
          end else if (pend_nz) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = (state_d == HIGH);
    busy  = (state_q != IDLE);
  end

  assign extra = in && !take_direct;

`ifdef PULSE_STRETCHER_QUEUE_EN
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              deq;

  assign pend_nz = (pend_q != '0);
  assign deq     = (state_q == pulse_pkg::GAP) && tmr_done && !in && pend_nz;

  // extra and deq are exclusive: deq requires in=0.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (extra) begin
      if (&pend_q) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (deq) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
`else
  assign pend_nz = 1'b0;
  assign drop    = extra;
  assign pending = '0;
`endif

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out       = out_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  a_out_in_high : assert property (@(posedge clk) disable iff (reset)
    out_q == (state_q == HIGH));
  a_pend_only_busy : assert property (@(posedge clk) disable iff (reset)
    (pending != '0) |-> (state_q != IDLE));
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (WIDTH=3, GAP=2, PEND_W=2); expected
// outputs come from an independent cycle model and are checked via a queue.
module tb_pulse_stretcher;

  localparam int WIDTH  = 3;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int EW     = PEND_W + 3;

  logic                    clk;
  logic                    reset;
  logic                    trig;
  logic                    clr_overflow;
  logic                    out;
  logic                    busy;
  logic [PEND_W-1:0]       pending;
  logic                    overflow;
  pulse_pkg::pulse_state_t dbg_state;

  int checks;
  int errors;

  logic [EW-1:0] exp_q[$];

  // model: remaining high cycles, remaining gap cycles, queue count, flag
  int m_hi;
  int m_gap;
  int m_pend;
  bit m_ovf;
  bit m_drop;

  pulse_stretcher #(
    .WIDTH  (WIDTH),
    .GAP    (GAP),
    .PEND_W (PEND_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (trig),
    .clr_overflow (clr_overflow),
    .out          (out),
    .busy         (busy),
    .pending      (pending),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hi   = 0;
    m_gap  = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic m_enqueue();
`ifdef PULSE_STRETCHER_QUEUE_EN
    if (m_pend == PMAX) m_drop = 1'b1;
    else m_pend++;
`else
    m_drop = 1'b1;
`endif
  endtask

  task automatic m_step(input bit t, input bit c);
    m_drop = 1'b0;
    if (m_hi == 0 && m_gap == 0) begin
      if (t) m_hi = WIDTH;
    end else if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) m_gap = GAP;
      if (t) m_enqueue();
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        if (t) m_hi = WIDTH;
        else if (m_pend > 0) begin
          m_pend--;
          m_hi = WIDTH;
        end
      end else if (t) begin
        m_enqueue();
      end
    end
    if (m_drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic step(input bit t, input bit c);
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    trig         = t;
    clr_overflow = c;
    m_step(t, c);
    exp_q.push_back({m_hi > 0, (m_hi > 0) || (m_gap > 0), PEND_W'(m_pend), m_ovf});
    @(posedge clk);
    #1;
    trig         = 1'b0;
    clr_overflow = 1'b0;
    g = {out, busy, pending, overflow};
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("out",      32'(g[EW-1]),       32'(e[EW-1]));
      check_eq("busy",     32'(g[EW-2]),       32'(e[EW-2]));
      check_eq("pending",  32'(g[PEND_W:1]),   32'(e[PEND_W:1]));
      check_eq("overflow", 32'(g[0]),          32'(e[0]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    trig         = 1'b0;
    clr_overflow = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out",   32'(out),       32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_pend",  32'(pending),   32'd0);
    check_eq("rst_ovf",   32'(overflow),  32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(pulse_pkg::IDLE));
    reset = 1'b0;
    idle(3);

    // single pulse
    step(1'b1, 1'b0);
    idle(8);

    // queued replay: three triggers during HIGH
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
    check_eq("q_pend3", 32'(pending), 32'd3);
`else
    check_eq("nq_pend0", 32'(pending), 32'd0);
    check_eq("nq_ovf",   32'(overflow), 32'd1);
`endif
    idle(25);

    // saturation, then clear
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check_eq("sat_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b1);
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    idle(25);

    // direct restart in the final GAP cycle
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    check_eq("dr_out", 32'(out), 32'd1);
`ifdef PULSE_STRETCHER_QUEUE_EN
    check_eq("dr_pend", 32'(pending), 32'd1);
`else
    check_eq("dr_pend", 32'(pending), 32'd0);
`endif
    idle(15);

    // asynchronous reset in the middle of HIGH
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_eq("ar_out",   32'(out),       32'd0);
    check_eq("ar_busy",  32'(busy),      32'd0);
    check_eq("ar_state", 32'(dbg_state), 32'(pulse_pkg::IDLE));
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0);
    idle(8);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    idle(30);

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
